indirect_seq: RTL and testbench

- Sequences the two-pass memory access of LDI/STI once the instruction reaches the mem stage.
- Pass 1 reads the pointer at the effective address. Pass 2 reads the data (LDI) or writes it (STI) at that pointer.
- Owns the data-cache handshake while active and holds the upstream pipeline with a stall. Replaces the per-cycle bubble-control-word injection in the execute stage.

---
 rtl/lc3b_types.sv | 36 +++
 rtl/sat_counter.sv | 23 ++
 rtl/indirect_seq.sv | 132 +++++++++++++
 tb/tb_indirect_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, opcode encoding and the indirect-access sequencer states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    FINAL,
    DONE
  } lc3b_ind_state;

  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at its all-ones value.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/indirect_seq.sv
// Two-pass LDI/STI sequencer in the mem stage: fetch the pointer, then read or write through it.
module indirect_seq
  import lc3b_types::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid,
  input  lc3b_opcode         mem_opcode,
  input  lc3b_word           mem_address,
  input  lc3b_word           mem_wdata,
  input  logic               flush,
  input  logic               dmem_resp,
  input  lc3b_word           dmem_rdata,
  output logic               dmem_read,
  output logic               dmem_write,
  output lc3b_word           dmem_address,
  output lc3b_word           dmem_wdata,
  output logic               ind_active,
  output logic               ind_done,
  output lc3b_word           ind_rdata,
  output logic [COUNT_W-1:0] ind_count
);

  lc3b_ind_state state_q, state_d;
  lc3b_word      addr_q, wdata_q, ptr_q, rdata_q;
  logic          is_store_q;
  logic          flush_pend_q, flush_pend_d;
  logic          accept;
  logic          count_inc;

  assign accept    = (state_q == IDLE) && mem_valid && is_indirect(mem_opcode) && !flush;
  assign count_inc = (state_q == DONE) && !flush_pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (accept) state_d = PTR;
      end
      PTR: begin
        if (dmem_resp) begin
          state_d = (flush_pend_q || flush) ? IDLE : FINAL;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      FINAL: begin
        if (dmem_resp) begin
          state_d = DONE;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      ptr_q        <= '0;
      rdata_q      <= '0;
      is_store_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
      if (accept) begin
        addr_q     <= mem_address;
        wdata_q    <= mem_wdata;
        is_store_q <= (mem_opcode == op_sti);
      end
      if ((state_q == PTR) && dmem_resp) ptr_q <= dmem_rdata;
      if ((state_q == FINAL) && dmem_resp && !is_store_q) rdata_q <= dmem_rdata;
    end
  end

  // Outputs depend only on state and registers (never on dmem_resp); reset forces them low.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    dmem_wdata   = '0;
    ind_active   = 1'b0;
    ind_done     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: ;
        PTR: begin
          dmem_read    = 1'b1;
          dmem_address = {addr_q[15:1], 1'b0};
          ind_active   = 1'b1;
        end
        FINAL: begin
          dmem_address = {ptr_q[15:1], 1'b0};
          ind_active   = 1'b1;
          if (is_store_q) begin
            dmem_write = 1'b1;
            dmem_wdata = wdata_q;
          end else begin
            dmem_read = 1'b1;
          end
        end
        DONE: ind_done = !flush_pend_q;
      endcase
    end
  end

  assign ind_rdata = rdata_q;

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .inc  (count_inc),
    .count(ind_count)
  );

endmodule

// File: tb/tb_indirect_seq.sv
// Directed bench for indirect_seq with a latency-programmable data-cache responder.
module tb_indirect_seq;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_valid;
  lc3b_opcode mem_opcode;
  lc3b_word   mem_address;
  lc3b_word   mem_wdata;
  logic       flush;
  logic       dmem_resp;
  lc3b_word   dmem_rdata;
  logic       dmem_read;
  logic       dmem_write;
  lc3b_word   dmem_address;
  lc3b_word   dmem_wdata;
  logic       ind_active;
  logic       ind_done;
  lc3b_word   ind_rdata;
  logic [1:0] ind_count;

  int        n_pass = 0;
  int        n_fail = 0;
  int        n_total = 0;
  int        lat = 1;
  int        wait_cnt = 0;
  logic      stray = 1'b0;
  lc3b_word  mem [lc3b_word];

  indirect_seq #(
    .COUNT_W(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_opcode  (mem_opcode),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .flush       (flush),
    .dmem_resp   (dmem_resp),
    .dmem_rdata  (dmem_rdata),
    .dmem_read   (dmem_read),
    .dmem_write  (dmem_write),
    .dmem_address(dmem_address),
    .dmem_wdata  (dmem_wdata),
    .ind_active  (ind_active),
    .ind_done    (ind_done),
    .ind_rdata   (ind_rdata),
    .ind_count   (ind_count)
  );

  always #5 clk = ~clk;

  // Cache model: answers a held request after `lat` cycles with a single-cycle resp pulse.
  initial begin
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (stray) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hDEAD;
      end else if (dmem_read || dmem_write) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          wait_cnt  = 0;
          dmem_resp = 1'b1;
          if (dmem_write) mem[dmem_address] = dmem_wdata;
          dmem_rdata = mem.exists(dmem_address) ? mem[dmem_address] : 16'h0000;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_read"}, 16'(dmem_read), 16'h0);
    chk({tag, "_write"}, 16'(dmem_write), 16'h0);
    chk({tag, "_addr"}, dmem_address, 16'h0);
    chk({tag, "_wdata"}, dmem_wdata, 16'h0);
    chk({tag, "_active"}, 16'(ind_active), 16'h0);
    chk({tag, "_done"}, 16'(ind_done), 16'h0);
  endtask

  task automatic issue(input lc3b_opcode op, input lc3b_word addr, input lc3b_word wd);
    mem_valid   = 1'b1;
    mem_opcode  = op;
    mem_address = addr;
    mem_wdata   = wd;
  endtask

  initial begin
    reset       = 1'b1;
    mem_valid   = 1'b0;
    mem_opcode  = op_add;
    mem_address = '0;
    mem_wdata   = '0;
    flush       = 1'b0;
    mem[16'h1000] = 16'h2002;
    mem[16'h2002] = 16'hBEEF;
    mem[16'h0400] = 16'h0600;
    mem[16'h3000] = 16'h4000;
    mem[16'h0500] = 16'h0700;

    // Reset state
    step();
    step();
    chk_quiet("rst_during");
    chk("rst_count", 16'(ind_count), 16'h0);
    chk("rst_rdata", ind_rdata, 16'h0);
    reset = 1'b0;
    step();
    chk_quiet("rst_after");

    // LDI basics, 1-cycle cache
    lat = 1;
    issue(op_ldi, 16'h1001, 16'h0);
    step();
    mem_valid = 1'b0;
    chk("ldi_p1_read", 16'(dmem_read), 16'h1);
    chk("ldi_p1_addr", dmem_address, 16'h1000);
    chk("ldi_p1_active", 16'(ind_active), 16'h1);
    chk("ldi_p1_done", 16'(ind_done), 16'h0);
    step();
    chk("ldi_p2_read", 16'(dmem_read), 16'h1);
    chk("ldi_p2_write", 16'(dmem_write), 16'h0);
    chk("ldi_p2_addr", dmem_address, 16'h2002);
    chk("ldi_p2_done", 16'(ind_done), 16'h0);
    step();
    chk("ldi_done", 16'(ind_done), 16'h1);
    chk("ldi_done_active", 16'(ind_active), 16'h0);
    chk("ldi_done_read", 16'(dmem_read), 16'h0);
    chk("ldi_rdata", ind_rdata, 16'hBEEF);
    step();
    chk_quiet("ldi_idle");
    chk("ldi_count", 16'(ind_count), 16'h1);

    // STI basics, 5-cycle cache
    lat = 5;
    issue(op_sti, 16'h0400, 16'h1234);
    step();
    mem_valid = 1'b0;
    mem_wdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("sti_p1_read", 16'(dmem_read), 16'h1);
      chk("sti_p1_addr", dmem_address, 16'h0400);
      chk("sti_p1_active", 16'(ind_active), 16'h1);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("sti_p2_write", 16'(dmem_write), 16'h1);
      chk("sti_p2_read", 16'(dmem_read), 16'h0);
      chk("sti_p2_addr", dmem_address, 16'h0600);
      chk("sti_p2_wdata", dmem_wdata, 16'h1234);
      chk("sti_p2_active", 16'(ind_active), 16'h1);
      chk("sti_p2_done", 16'(ind_done), 16'h0);
      step();
    end
    chk("sti_done", 16'(ind_done), 16'h1);
    step();
    chk_quiet("sti_idle");
    chk("sti_count", 16'(ind_count), 16'h2);
    chk("sti_mem", mem[16'h0600], 16'h1234);

    // Flush during pointer fetch: no second pass, no done
    lat = 3;
    issue(op_ldi, 16'h3000, 16'h0);
    step();
    mem_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    chk("fptr_held_read", 16'(dmem_read), 16'h1);
    chk("fptr_held_addr", dmem_address, 16'h3000);
    step();
    chk("fptr_held2_read", 16'(dmem_read), 16'h1);
    step();
    chk_quiet("fptr_idle");
    step();
    chk_quiet("fptr_idle2");
    chk("fptr_count", 16'(ind_count), 16'h2);
    chk("fptr_rdata", ind_rdata, 16'hBEEF);

    // Flush in IDLE blocks acceptance
    lat = 1;
    issue(op_ldi, 16'h1000, 16'h0);
    flush = 1'b1;
    step();
    mem_valid = 1'b0;
    flush     = 1'b0;
    chk_quiet("fidle");
    step();
    chk_quiet("fidle2");

    // Flush during STI write pass: write completes, done suppressed
    lat = 2;
    issue(op_sti, 16'h0500, 16'h5555);
    step();
    mem_valid = 1'b0;
    step();
    step();
    chk("ffin_write", 16'(dmem_write), 16'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ffin_held_write", 16'(dmem_write), 16'h1);
    chk("ffin_held_addr", dmem_address, 16'h0700);
    chk("ffin_held_wdata", dmem_wdata, 16'h5555);
    chk("ffin_held_active", 16'(ind_active), 16'h1);
    step();
    chk_quiet("ffin_done_slot");
    step();
    chk_quiet("ffin_idle");
    chk("ffin_count", 16'(ind_count), 16'h2);
    chk("ffin_mem", mem[16'h0700], 16'h5555);

    // Reset mid-sequence, then a stray response
    lat = 1;
    issue(op_ldi, 16'h1000, 16'h0);
    step();
    mem_valid = 1'b0;
    step();
    chk("rmid_final_addr", dmem_address, 16'h2002);
    reset = 1'b1;
    #1;
    chk("rmid_during_read", 16'(dmem_read), 16'h0);
    step();
    reset = 1'b0;
    chk_quiet("rmid_after");
    chk("rmid_count", 16'(ind_count), 16'h0);
    chk("rmid_rdata", ind_rdata, 16'h0);
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    chk_quiet("stray");
    chk("stray_rdata", ind_rdata, 16'h0);

    // Back-to-back LDIs with mem_valid held; 2-bit counter saturates at 3
    issue(op_ldi, 16'h1000, 16'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("b2b_p1_addr", dmem_address, 16'h1000);
      chk("b2b_p1_read", 16'(dmem_read), 16'h1);
      step();
      chk("b2b_p2_addr", dmem_address, 16'h2002);
      step();
      chk("b2b_done", 16'(ind_done), 16'h1);
      chk("b2b_done_active", 16'(ind_active), 16'h0);
      chk("b2b_count_pre", 16'(ind_count), 16'((k < 3) ? k : 3));
      if (k == 4) mem_valid = 1'b0;
      step();
      chk_quiet("b2b_gap");
      chk("b2b_count", 16'(ind_count), 16'((k + 1 < 3) ? k + 1 : 3));
      step();
    end
    chk_quiet("b2b_end");
    chk("b2b_sat", 16'(ind_count), 16'h3);
    chk("b2b_rdata", ind_rdata, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
